uart_rx_os: RTL and testbench

Stand-alone UART receiver for the far end of the serial line driven by the UART transmit path. It samples an asynchronous serial input directly on SysClk using 16x oversampling and 3-sample majority voting. Each frame is 8 data bits LSB-first, optional parity and 1 stop bit. Received bytes and error flags are presented to the SRAM write side through a valid/read handshake.

---
 rtl/uart_rx_os_if.sv | 13 +
 rtl/uart_rx_os.sv | 144 ++++++++++++++
 tb/tb_uart_rx_os.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_os_if.sv
// Read-side handshake between the UART receiver and the SRAM write logic.
// The receiver (master) presents a byte plus error flags; the consumer pulses rd_en.
interface uart_rx_os_if;
   logic       rd_en;
   logic [7:0] data_out;
   logic       data_valid;
   logic       PE;
   logic       FE;
   logic       OE;

   modport master (input rd_en, output data_out, data_valid, PE, FE, OE);
   modport slave  (output rd_en, input data_out, data_valid, PE, FE, OE);
endinterface

// File: rtl/uart_rx_os.sv
// UART receiver: 16x oversampling of a 2-flop synchronized line, 3-point majority
// vote per bit, 8N1/8E1/8O1 framing, single-entry output register with overrun flag.
module uart_rx_os #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int SAMPLE   = 16
) (
   input  logic         SysClk,
   input  logic         rst,
   input  logic [1:0]   baud_selector,
   input  logic         parity_en,
   input  logic         parity_sel,
   input  logic         rx_serial,
   uart_rx_os_if.master rx_if
);
   localparam int BASE_BAUD = 2400;
   localparam int DW        = $clog2(CLK_FREQ / (BASE_BAUD * SAMPLE));

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state_reg, state_next;
   logic          rx_meta_reg, rx_s_reg;
   logic          armed_reg;
   logic [DW-1:0] div_cnt_reg;
   logic [3:0]    tc_reg;
   logic [2:0]    bit_idx_reg;
   logic [1:0]    samp_reg;
   logic [7:0]    shift_reg;
   logic [1:0]    baud_reg;
   logic          par_en_reg, par_sel_reg, perr_reg;
   logic [7:0]    data_out_reg;
   logic          data_valid_reg, pe_reg, fe_reg, oe_reg;

   // Terminal count of the tick divider for each baud setting (2400 << index).
   logic [DW-1:0] div_m1 [4];
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_div
         assign div_m1[gi] = DW'(CLK_FREQ / ((BASE_BAUD << gi) * SAMPLE) - 1);
      end
   endgenerate

   logic start_det, tick, at_vote, at_end, vote, frame_done;

   assign start_det  = (state_reg == IDLE) && armed_reg && !rx_s_reg;
   assign tick       = (state_reg != IDLE) && (div_cnt_reg == div_m1[baud_reg]);
   assign at_vote    = tick && (tc_reg == 4'd9);
   assign at_end     = tick && (tc_reg == 4'd15);
   assign vote       = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s_reg) |
                       (samp_reg[1] & rx_s_reg);
   assign frame_done = (state_reg == STOP) && at_vote;

   always_ff @(posedge SysClk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (start_det) state_next = START;
         START: begin
            if (at_vote && vote) state_next = IDLE;
            else if (at_end)     state_next = DATA;
         end
         DATA:    if (at_end && bit_idx_reg == 3'd7) state_next = par_en_reg ? PARITY : STOP;
         PARITY:  if (at_end)  state_next = STOP;
         STOP:    if (at_vote) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge SysClk) begin
      if (rst) begin
         rx_meta_reg    <= 1'b1;
         rx_s_reg       <= 1'b1;
         armed_reg      <= 1'b1;
         div_cnt_reg    <= '0;
         tc_reg         <= 4'd0;
         bit_idx_reg    <= 3'd0;
         samp_reg       <= 2'b11;
         shift_reg      <= 8'h00;
         baud_reg       <= 2'b00;
         par_en_reg     <= 1'b0;
         par_sel_reg    <= 1'b0;
         perr_reg       <= 1'b0;
         data_out_reg   <= 8'h00;
         data_valid_reg <= 1'b0;
         pe_reg         <= 1'b0;
         fe_reg         <= 1'b0;
         oe_reg         <= 1'b0;
      end else begin
         rx_meta_reg <= rx_serial;
         rx_s_reg    <= rx_meta_reg;

         // Bit timing restarts on the start edge; config is frozen for the frame.
         if (start_det) begin
            div_cnt_reg <= '0;
            tc_reg      <= 4'd0;
            bit_idx_reg <= 3'd0;
            perr_reg    <= 1'b0;
            baud_reg    <= baud_selector;
            par_en_reg  <= parity_en;
            par_sel_reg <= parity_sel;
         end else if (tick) begin
            div_cnt_reg <= '0;
            tc_reg      <= tc_reg + 4'd1;
         end else if (state_reg != IDLE) begin
            div_cnt_reg <= div_cnt_reg + DW'(1);
         end

         if (tick && tc_reg == 4'd7) samp_reg[0] <= rx_s_reg;
         if (tick && tc_reg == 4'd8) samp_reg[1] <= rx_s_reg;

         if (state_reg == DATA && at_vote) shift_reg[bit_idx_reg] <= vote;
         if (state_reg == DATA && at_end)  bit_idx_reg <= bit_idx_reg + 3'd1;
         if (state_reg == PARITY && at_vote)
            perr_reg <= ((^shift_reg) ^ vote) != par_sel_reg;

         // After a break the line must be seen idle before a new start is accepted.
         if (state_reg == IDLE && rx_s_reg) armed_reg <= 1'b1;

         if (frame_done) begin
            if (!vote && shift_reg == 8'h00) armed_reg <= 1'b0;
            if (!data_valid_reg || rx_if.rd_en) begin
               data_out_reg   <= shift_reg;
               pe_reg         <= perr_reg;
               fe_reg         <= !vote;
               data_valid_reg <= 1'b1;
            end else begin
               oe_reg <= 1'b1;
            end
         end else if (rx_if.rd_en && data_valid_reg) begin
            data_valid_reg <= 1'b0;
            oe_reg         <= 1'b0;
         end
      end
   end

   assign rx_if.data_out   = data_out_reg;
   assign rx_if.data_valid = data_valid_reg;
   assign rx_if.PE         = pe_reg;
   assign rx_if.FE         = fe_reg;
   assign rx_if.OE         = oe_reg;
endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: table of frames plus hand-built overrun, break, glitch and
// reset sequences; received frames are checked against a scoreboard queue.
module tb_uart_rx_os;
   // Scaled clock keeps runtime short: divisors 40/20/10/5 for 2400..19200 baud.
   localparam int CLK_FREQ = 1_536_000;

   logic       SysClk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] baud_selector = 2'b10;
   logic       parity_en = 1'b0;
   logic       parity_sel = 1'b0;
   logic       rx_serial = 1'b1;
   logic       rd_man = 1'b0;
   logic       rd_auto = 1'b0;
   logic       auto_read = 1'b0;

   uart_rx_os_if bus();
   assign bus.rd_en = rd_auto | rd_man;

   uart_rx_os #(.CLK_FREQ(CLK_FREQ), .SAMPLE(16)) dut (
      .SysClk       (SysClk),
      .rst          (rst),
      .baud_selector(baud_selector),
      .parity_en    (parity_en),
      .parity_sel   (parity_sel),
      .rx_serial    (rx_serial),
      .rx_if        (bus)
   );

   always #5 SysClk = ~SysClk;

   typedef struct {
      logic [7:0] data;
      logic       pe;
      logic       fe;
   } exp_t;

   typedef struct {
      logic [1:0] baud;
      logic       pen;
      logic       psel;
      logic [7:0] data;
      logic       pbit;
      logic       stop;
      int         noise_bit;
      logic [7:0] exp_data;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[8];
   int   n_checks = 0;
   int   n_fail = 0;
   int   rise_count = 0;
   logic prev_valid = 1'b0;

   function automatic int div_of(input logic [1:0] b);
      case (b)
         2'b00:   return 40;
         2'b01:   return 20;
         2'b10:   return 10;
         default: return 5;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   function automatic logic [11:0] bus_state();
      return {bus.data_out, bus.data_valid, bus.PE, bus.FE, bus.OE};
   endfunction

   // Monitor: every rising data_valid is a delivered frame and must match the queue head.
   always @(negedge SysClk) begin
      exp_t e;
      rd_auto = 1'b0;
      if (bus.data_valid && !prev_valid) begin
         rise_count++;
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got data %0h, expected no frame", bus.data_out);
         end else begin
            e = sb_q.pop_front();
            check("rx_frame", {21'h0, bus.data_out, bus.PE, bus.FE, bus.OE},
                  {21'h0, e.data, e.pe, e.fe, 1'b0});
         end
         if (auto_read) rd_auto = 1'b1;
      end
      prev_valid = bus.data_valid;
   end

   // One bit period; optionally a single-cycle low pulse aimed at the tc=8 sample.
   task automatic drive_bit(input logic v, input int div, input bit noise);
      rx_serial = v;
      if (noise) begin
         repeat (9 * div) @(negedge SysClk);
         rx_serial = 1'b0;
         @(negedge SysClk);
         rx_serial = v;
         repeat (7 * div - 1) @(negedge SysClk);
      end else begin
         repeat (16 * div) @(negedge SysClk);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                             input logic stop, input int div, input int noise_bit);
      drive_bit(1'b0, div, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i], div, i == noise_bit);
      if (pen) drive_bit(pbit, div, 1'b0);
      drive_bit(stop, div, 1'b0);
   endtask

   task automatic rd_pulse();
      rd_man = 1'b1;
      @(negedge SysClk);
      rd_man = 1'b0;
   endtask

   initial begin
      int r0;
      vecs[0] = '{2'b10, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{2'b10, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1, -1, 8'h07, 1'b0, 1'b0};
      vecs[2] = '{2'b10, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1, -1, 8'h07, 1'b1, 1'b0};
      vecs[3] = '{2'b10, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, -1, 8'h07, 1'b0, 1'b0};
      vecs[4] = '{2'b10, 1'b1, 1'b1, 8'h07, 1'b1, 1'b1, -1, 8'h07, 1'b1, 1'b0};
      vecs[5] = '{2'b01, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, -1, 8'hC3, 1'b0, 1'b0};
      vecs[6] = '{2'b00, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, -1, 8'h81, 1'b0, 1'b0};
      vecs[7] = '{2'b10, 1'b0, 1'b0, 8'h6B, 1'b0, 1'b1,  0, 8'h6B, 1'b0, 1'b0};

      repeat (4) @(negedge SysClk);
      check("reset_state", {20'h0, bus_state()}, 32'h0);
      rst = 1'b0;
      repeat (20) @(negedge SysClk);

      for (int i = 0; i < 8; i++) begin
         baud_selector = vecs[i].baud;
         parity_en     = vecs[i].pen;
         parity_sel    = vecs[i].psel;
         sb_q.push_back('{vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe});
         send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].stop,
                    div_of(vecs[i].baud), vecs[i].noise_bit);
         repeat (4) @(negedge SysClk);
         check("vec_frame_seen", sb_q.size(), 0);
         rd_pulse();
         check("vec_rd_clears_valid", {31'h0, bus.data_valid}, 0);
         repeat (16 * div_of(vecs[i].baud)) @(negedge SysClk);
      end

      baud_selector = 2'b10;
      parity_en     = 1'b0;

      // Overrun: second byte discarded, OE set; read clears OE and valid.
      sb_q.push_back('{8'h11, 1'b0, 1'b0});
      send_frame(8'h11, 1'b0, 1'b0, 1'b1, 10, -1);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1, 10, -1);
      repeat (4) @(negedge SysClk);
      check("overrun_hold", {20'h0, bus_state()}, {20'h0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1});
      rd_pulse();
      check("overrun_rd", {20'h0, bus_state()}, {20'h0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0});
      repeat (40) @(negedge SysClk);

      // rd_en exactly on the completion cycle: new byte accepted, no overrun.
      sb_q.push_back('{8'h11, 1'b0, 1'b0});
      send_frame(8'h11, 1'b0, 1'b0, 1'b1, 10, -1);
      fork
         send_frame(8'h22, 1'b0, 1'b0, 1'b1, 10, -1);
         begin
            repeat (154 * 10 + 2) @(negedge SysClk);
            rd_man = 1'b1;
            @(negedge SysClk);
            rd_man = 1'b0;
         end
      join
      check("rd_on_completion", {20'h0, bus_state()}, {20'h0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0});
      rd_pulse();
      repeat (40) @(negedge SysClk);

      // Framing error followed by a held-low line: exactly one 0x00 break frame.
      auto_read = 1'b1;
      r0 = rise_count;
      sb_q.push_back('{8'h3C, 1'b0, 1'b1});
      sb_q.push_back('{8'h00, 1'b0, 1'b1});
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 10, -1);
      repeat (3 * 160 * 10) @(negedge SysClk);
      check("break_frame_count", rise_count - r0, 2);
      check("break_queue_empty", sb_q.size(), 0);
      rx_serial = 1'b1;
      repeat (32 * 10) @(negedge SysClk);
      auto_read = 1'b0;

      // Short low glitch on an idle line is rejected by the start-bit vote.
      r0 = rise_count;
      rx_serial = 1'b0;
      repeat (3 * 10) @(negedge SysClk);
      rx_serial = 1'b1;
      repeat (2 * 160 * 10) @(negedge SysClk);
      check("glitch_no_frame", {(rise_count - r0), bus.data_valid}, 0);

      sb_q.push_back('{8'h5A, 1'b0, 1'b0});
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 10, -1);
      repeat (4) @(negedge SysClk);
      check("rearm_frame_seen", sb_q.size(), 0);

      // Reset in the middle of 0x55 data bits, then a clean 19200-baud frame.
      drive_bit(1'b0, 10, 1'b0);
      drive_bit(1'b1, 10, 1'b0);
      drive_bit(1'b0, 10, 1'b0);
      drive_bit(1'b1, 10, 1'b0);
      rx_serial = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge SysClk);
      check("mid_frame_reset", {20'h0, bus_state()}, 32'h0);
      repeat (3) @(negedge SysClk);
      rst = 1'b0;
      repeat (32 * 10) @(negedge SysClk);
      baud_selector = 2'b11;
      sb_q.push_back('{8'h9A, 1'b0, 1'b0});
      send_frame(8'h9A, 1'b0, 1'b0, 1'b1, 5, -1);
      repeat (4) @(negedge SysClk);
      check("fast_frame_seen", sb_q.size(), 0);
      check("fast_frame_state", {20'h0, bus_state()}, {20'h0, 8'h9A, 1'b1, 1'b0, 1'b0, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
